// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-by-vector datapath and its sequencer.
// Holds the strobe vector types used on the datapath boundary, the sequencer
// state encoding and the step tag that rides the delayed-control pipe.
package mxv_pkg;

    localparam int N_COLS = 8;                 // columns per row, one FIFO each
    localparam int N_PROC = 4;                 // processors A..D
    localparam int STEP_W = $clog2(N_COLS);    // width of a COMPUTE step index
    localparam int LANE_W = $clog2(N_PROC);    // width of a processor index

    typedef logic [N_COLS-1:0] push_pop_t;     // one-hot matrix FIFO strobe
    typedef logic [N_PROC-1:0] sltr_4_t;       // one-hot vector demux select
    typedef logic              sltr_2_t;       // two-way mux select

    typedef enum logic [2:0] {
        IDLE,
        LOAD_VEC,
        LOAD_ROW,
        COMPUTE,
        DRAIN,
        DONE
    } ctrl_state_e;

    // Tag issued with every FIFO pop; the delayed controls are decoded from it.
    typedef struct packed {
        logic              vld;
        logic [STEP_W-1:0] step;
    } mxv_ctrl_st;

    function automatic push_pop_t step_onehot(input logic [STEP_W-1:0] s);
        return push_pop_t'(1) << s;
    endfunction

endpackage

// File: rtl/mxv_ctrl_dly.sv
// Delayed-control pipe for the matrix-by-vector sequencer.
// The step tag of each pop travels RD_LAT cycles (FIFO read latency) and is then
// decoded into the demux select, processor enable and mux selects for that step.
// Step 7's enable travels a further PROC_LAT cycles to become push_result.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   tag_in       step tag of the pop issued this cycle
//   dmx_v_sltr   one-hot vector demux select
//   ena_proc     processor enables, bit 0 = A
//   mx_sltr      per-processor FIFO half select, bit 0 = A (1 = FIFOs 4..7)
//   mx_reg_sltr  feed result_reg_d back into processor A
//   push_result  result FIFO push, one per row
module mxv_ctrl_dly
    import mxv_pkg::*;
#(
    parameter int RD_LAT   = 1,   // must be >= 1
    parameter int PROC_LAT = 1    // must be >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  mxv_ctrl_st tag_in,
    output sltr_4_t    dmx_v_sltr,
    output sltr_4_t    ena_proc,
    output sltr_4_t    mx_sltr,
    output sltr_2_t    mx_reg_sltr,
    output logic       push_result
);

    mxv_ctrl_st             rd_pipe   [RD_LAT];
    logic                   push_pipe [PROC_LAT];
    mxv_ctrl_st             tag_d;
    logic [LANE_W-1:0]      lane;
    logic                   upper_half;
    logic                   last_step;

    // NOTE: these shift registers carry strobes, not data, so every stage is
    // reset; a stale valid bit would fire a processor enable after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
            for (int i = 0; i < PROC_LAT; i++) push_pipe[i] <= 1'b0;
        end else begin
            rd_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            push_pipe[0] <= last_step;
            for (int i = 1; i < PROC_LAT; i++) push_pipe[i] <= push_pipe[i-1];
        end
    end

    assign tag_d       = rd_pipe[RD_LAT-1];
    assign lane        = tag_d.step[LANE_W-1:0];
    assign upper_half  = tag_d.step[STEP_W-1];
    assign last_step   = tag_d.vld && (tag_d.step == STEP_W'(N_COLS - 1));
    assign push_result = push_pipe[PROC_LAT-1];

    // NOTE: every output is given a default before the if, so no path through
    // this block leaves a value held over and no latch is inferred.
    always_comb begin
        dmx_v_sltr  = '0;
        ena_proc    = '0;
        mx_sltr     = '0;
        mx_reg_sltr = 1'b0;
        if (tag_d.vld) begin
            dmx_v_sltr[lane] = 1'b1;
            ena_proc[lane]   = 1'b1;
            mx_sltr[lane]    = upper_half;
            mx_reg_sltr      = upper_half;
        end
    end

endmodule

// File: rtl/mxv_seq_ctrl.sv
// Upstream sequencer for the matrix-by-vector datapath.
// Loads one 8-beat vector and one 8-beat matrix row per row of the frame, then
// pops the FIFOs for 8 COMPUTE steps. Results are counted and served to the host.
// A row only enters COMPUTE when the result FIFO can take its result.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, n_rows            frame request (sampled in IDLE only)
//   in_valid, in_ready       host beat handshake
//   push_vector, push_matrix vector / one-hot matrix FIFO pushes
//   pop_vector, pop_matrix   vector / one-hot matrix FIFO pops
//   dmx_v_sltr, mx_*_sltr    delayed datapath selectors
//   ena_proc_a..d            delayed processor enables
//   push_result, pop_result  result FIFO strobes
//   res_pop, res_avail       host result interface
//   busy, done               frame status
module mxv_seq_ctrl
    import mxv_pkg::*;
#(
    parameter int ROW_W     = 4,
    parameter int RD_LAT    = 1,
    parameter int PROC_LAT  = 1,
    parameter int RES_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] n_rows,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             push_vector,
    output push_pop_t        push_matrix,
    output logic             pop_vector,
    output push_pop_t        pop_matrix,
    output sltr_4_t          dmx_v_sltr,
    output sltr_2_t          mx_reg_sltr,
    output sltr_2_t          mx_a_sltr,
    output sltr_2_t          mx_b_sltr,
    output sltr_2_t          mx_c_sltr,
    output sltr_2_t          mx_d_sltr,
    output logic             ena_proc_a,
    output logic             ena_proc_b,
    output logic             ena_proc_c,
    output logic             ena_proc_d,
    output logic             push_result,
    input  logic             res_pop,
    output logic             pop_result,
    output logic             res_avail,
    output logic             busy,
    output logic             done
);

    localparam int COL_W = STEP_W + 1;   // one extra code marks the stall hold
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLS - 1);
    localparam logic [COL_W-1:0]  COL_HOLD  = COL_W'(N_COLS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_COLS - 1);

    ctrl_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q;
    logic [STEP_W-1:0] step_q;
    logic [ROW_W-1:0]  row_q, n_rows_q;
    logic [CNT_W-1:0]  res_cnt_q, in_flight_q;
    logic [CNT_W:0]    occupancy;
    logic              space;
    logic              beat;
    logic              enter_compute;
    logic              last_row;
    mxv_ctrl_st        pop_tag;
    sltr_4_t           ena_vec, mx_vec;

    // Results already queued plus rows still travelling through the processors.
    assign occupancy     = {1'b0, res_cnt_q} + {1'b0, in_flight_q};
    assign space         = occupancy < (CNT_W + 1)'(RES_DEPTH);
    assign beat          = in_valid && in_ready;
    assign enter_compute = (state_q == LOAD_ROW) && (state_d == COMPUTE);
    assign last_row      = (row_q == n_rows_q - ROW_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        push_vector = 1'b0;
        push_matrix = '0;
        pop_vector  = 1'b0;
        pop_matrix  = '0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = (n_rows == '0) ? DONE : LOAD_VEC;
            end
            LOAD_VEC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    push_vector = 1'b1;
                    if (col_q == COL_LAST) state_d = LOAD_ROW;
                end
            end
            LOAD_ROW: begin
                // After the 8th beat the row waits here, closed to the host,
                // until the result FIFO has room for one more result.
                if (col_q == COL_HOLD) begin
                    if (space) state_d = COMPUTE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        push_matrix = step_onehot(col_q[STEP_W-1:0]);
                        if (col_q == COL_LAST && space) state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                pop_vector = 1'b1;
                pop_matrix = step_onehot(step_q);
                if (step_q == STEP_LAST) state_d = last_row ? DRAIN : LOAD_VEC;
            end
            DRAIN: begin
                if (push_result && in_flight_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every counter
    // here sees the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q       <= '0;
            step_q      <= '0;
            row_q       <= '0;
            n_rows_q    <= '0;
            res_cnt_q   <= '0;
            in_flight_q <= '0;
        end else begin
            if (beat) begin
                if (col_q == COL_LAST)
                    col_q <= (state_q == LOAD_ROW && !space) ? COL_HOLD : '0;
                else
                    col_q <= col_q + COL_W'(1);
            end else if (enter_compute) begin
                col_q <= '0;
            end

            // Wraps back to 0 after the last step of the row.
            if (state_q == COMPUTE) step_q <= step_q + STEP_W'(1);

            if (state_q == IDLE && start) begin
                row_q    <= '0;
                n_rows_q <= n_rows;
            end else if (state_q == COMPUTE && step_q == STEP_LAST) begin
                row_q <= row_q + ROW_W'(1);
            end

            case ({enter_compute, push_result})
                2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
                2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
                default: ;
            endcase

            case ({push_result, pop_result})
                2'b10:   res_cnt_q <= res_cnt_q + CNT_W'(1);
                2'b01:   res_cnt_q <= res_cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign pop_tag = '{vld: (state_q == COMPUTE), step: step_q};

    mxv_ctrl_dly #(
        .RD_LAT   (RD_LAT),
        .PROC_LAT (PROC_LAT)
    ) u_dly (
        .clk         (clk),
        .rst         (rst),
        .tag_in      (pop_tag),
        .dmx_v_sltr  (dmx_v_sltr),
        .ena_proc    (ena_vec),
        .mx_sltr     (mx_vec),
        .mx_reg_sltr (mx_reg_sltr),
        .push_result (push_result)
    );

    assign ena_proc_a = ena_vec[0];
    assign ena_proc_b = ena_vec[1];
    assign ena_proc_c = ena_vec[2];
    assign ena_proc_d = ena_vec[3];
    assign mx_a_sltr  = mx_vec[0];
    assign mx_b_sltr  = mx_vec[1];
    assign mx_c_sltr  = mx_vec[2];
    assign mx_d_sltr  = mx_vec[3];

    assign res_avail  = (res_cnt_q != '0);
    assign pop_result = res_pop && res_avail;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mxv_seq_ctrl.sv
module tb_mxv_seq_ctrl;

    localparam int ROW_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, in_valid, res_pop;
    logic [ROW_W-1:0] n_rows;
    logic             in_ready, push_vector, pop_vector;
    logic [7:0]       push_matrix, pop_matrix;
    logic [3:0]       dmx_v_sltr;
    logic             mx_reg_sltr, mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr;
    logic             ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d;
    logic             push_result, pop_result, res_avail, busy, done;
    logic [36:0]      outs;

    mxv_seq_ctrl #(
        .ROW_W(ROW_W), .RD_LAT(1), .PROC_LAT(1), .RES_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
        .in_valid(in_valid), .in_ready(in_ready),
        .push_vector(push_vector), .push_matrix(push_matrix),
        .pop_vector(pop_vector), .pop_matrix(pop_matrix),
        .dmx_v_sltr(dmx_v_sltr), .mx_reg_sltr(mx_reg_sltr),
        .mx_a_sltr(mx_a_sltr), .mx_b_sltr(mx_b_sltr),
        .mx_c_sltr(mx_c_sltr), .mx_d_sltr(mx_d_sltr),
        .ena_proc_a(ena_proc_a), .ena_proc_b(ena_proc_b),
        .ena_proc_c(ena_proc_c), .ena_proc_d(ena_proc_d),
        .push_result(push_result), .res_pop(res_pop), .pop_result(pop_result),
        .res_avail(res_avail), .busy(busy), .done(done)
    );

    assign outs = {in_ready, push_vector, push_matrix, pop_vector, pop_matrix,
                   dmx_v_sltr, mx_reg_sltr, mx_a_sltr, mx_b_sltr, mx_c_sltr,
                   mx_d_sltr, ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d,
                   push_result, pop_result, res_avail, busy, done};

    int passed = 0;
    int total  = 0;

    // Cycle counter and strobe logs, sampled on the falling edge.
    int         cyc = 0;
    int         pv_n, popv_n, mxr_n, ena_n, strobe_n;
    logic [7:0] pm_q[$];
    logic [7:0] pop_q[$];
    int         pop_cyc_q[$];
    int         ena_a_q[$];
    int         mxa_q[$];
    int         pr_q[$];
    int         prs_q[$];
    int         done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (push_vector) pv_n++;
        if (push_matrix != 8'h00) pm_q.push_back(push_matrix);
        if (pop_vector) popv_n++;
        if (pop_matrix != 8'h00) begin
            pop_q.push_back(pop_matrix);
            pop_cyc_q.push_back(cyc);
        end
        if (ena_proc_a) ena_a_q.push_back(cyc);
        if (mx_a_sltr) mxa_q.push_back(cyc);
        if (mx_reg_sltr) mxr_n++;
        if (ena_proc_a || ena_proc_b || ena_proc_c || ena_proc_d) ena_n++;
        if (push_result) pr_q.push_back(cyc);
        if (pop_result) prs_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (in_ready || push_vector || push_matrix != 8'h00 || pop_vector ||
            pop_matrix != 8'h00 || push_result || dmx_v_sltr != 4'h0 ||
            ena_proc_a || ena_proc_b || ena_proc_c || ena_proc_d)
            strobe_n++;
    end

    task automatic clear_logs();
        pv_n = 0; popv_n = 0; mxr_n = 0; ena_n = 0; strobe_n = 0;
        pm_q.delete(); pop_q.delete(); pop_cyc_q.delete(); ena_a_q.delete();
        mxa_q.delete(); pr_q.delete(); prs_q.delete(); done_q.delete();
    endtask

    // Leaves the bench at 1 time unit after a rising edge, like every task here.
    task automatic do_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; res_pop = 1'b0; n_rows = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic run_frame(input int n, input bit toggle, input bit poke, input int limit);
        int k;
        int d0;
        d0 = done_q.size();
        start = 1'b1; n_rows = ROW_W'(n); in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n_rows = '1;   // frame must use the latched row count
        k = 0;
        while (done_q.size() == d0 && k < limit) begin
            in_valid = toggle ? k[0] : 1'b1;
            start    = poke && busy && (k % 5 == 2);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0; in_valid = 1'b0;
        total++;
        if (done_q.size() == d0)
            $display("FAIL frame_timeout: done not seen within %0d cycles (n_rows=%0d)", limit, n);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (outs !== 37'h0) $display("FAIL por_outputs: got %h expected 0", outs);
        else passed++;
        // Start a two-row frame and stop four beats into LOAD_ROW.
        start = 1'b1; n_rows = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        total++;
        if (pm_q.size() !== 4) $display("FAIL rst_pre_row_beats: got %0d expected 4", pm_q.size());
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        total++;
        if (outs !== 37'h0) $display("FAIL rst_mid_outputs: got %h expected 0", outs);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy);
        else passed++;
        // in_valid is still high: nothing may be accepted in IDLE.
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || push_vector !== 1'b0)
            $display("FAIL rst_idle_accept: in_ready=%b push_vector=%b expected 0 0", in_ready, push_vector);
        else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_single_row();
        int         t0;
        logic [7:0] exp_v;
        do_reset();
        run_frame(1, 1'b0, 1'b0, 100);
        total++;
        if (pv_n !== 8) $display("FAIL single_push_vector: got %0d expected 8", pv_n);
        else passed++;
        total++;
        if (pm_q.size() !== 8) $display("FAIL single_push_matrix_n: got %0d expected 8", pm_q.size());
        else passed++;
        for (int i = 0; i < 8; i++) begin
            exp_v = 8'h01 << i;
            total++;
            if (i >= pm_q.size() || pm_q[i] !== exp_v)
                $display("FAIL single_push_matrix[%0d]: got %h expected %h", i,
                         (i < pm_q.size()) ? pm_q[i] : 8'h00, exp_v);
            else passed++;
        end
        t0 = (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : 0;
        total++;
        if (pop_q.size() !== 8 || popv_n !== 8)
            $display("FAIL single_pop_n: got matrix %0d vector %0d expected 8 8", pop_q.size(), popv_n);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            exp_v = 8'h01 << i;
            total++;
            if (i >= pop_q.size() || pop_q[i] !== exp_v || pop_cyc_q[i] !== t0 + i)
                $display("FAIL single_pop_matrix[%0d]: got %h at cycle +%0d expected %h at +%0d", i,
                         (i < pop_q.size()) ? pop_q[i] : 8'h00,
                         (i < pop_q.size()) ? pop_cyc_q[i] - t0 : -1, exp_v, i);
            else passed++;
        end
        total++;
        if (ena_a_q.size() !== 2 || ena_a_q[0] !== t0 + 1 || ena_a_q[1] !== t0 + 5)
            $display("FAIL single_ena_a: got %0d pulses first at +%0d expected pulses at +1 and +5",
                     ena_a_q.size(), (ena_a_q.size() > 0) ? ena_a_q[0] - t0 : -1);
        else passed++;
        total++;
        if (ena_n !== 8) $display("FAIL single_ena_total: got %0d expected 8", ena_n);
        else passed++;
        total++;
        if (mxa_q.size() !== 1 || mxa_q[0] !== t0 + 5)
            $display("FAIL single_mx_a: got %0d pulses expected 1 at +5", mxa_q.size());
        else passed++;
        total++;
        if (mxr_n !== 4) $display("FAIL single_mx_reg: got %0d cycles expected 4", mxr_n);
        else passed++;
        total++;
        if (pr_q.size() !== 1 || pr_q[0] !== t0 + 9)
            $display("FAIL single_push_result: got %0d pulses first at +%0d expected 1 at +9",
                     pr_q.size(), (pr_q.size() > 0) ? pr_q[0] - t0 : -1);
        else passed++;
        total++;
        if (done_q.size() !== 1 || done_q[0] !== t0 + 10)
            $display("FAIL single_done: got %0d pulses first at +%0d expected 1 at +10",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1);
        else passed++;
        total++;
        if (busy !== 1'b0 || res_avail !== 1'b1)
            $display("FAIL single_end_state: busy=%b res_avail=%b expected 0 1", busy, res_avail);
        else passed++;
    endtask

    task automatic test_zero_rows();
        int c0;
        do_reset();
        c0 = cyc;
        start = 1'b1; n_rows = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        total++;
        if (done_q.size() !== 1 || done_q[0] !== c0 + 1)
            $display("FAIL zero_done: got %0d pulses first at +%0d expected 1 at +1",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] - c0 : -1);
        else passed++;
        total++;
        if (strobe_n !== 0) $display("FAIL zero_strobes: got %0d strobe cycles expected 0", strobe_n);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        int         bad;
        do_reset();
        res_pop = 1'b1;
        run_frame(2, 1'b1, 1'b1, 400);
        repeat (6) begin @(posedge clk); #1; end
        res_pop = 1'b0;
        total++;
        if (pv_n !== 16) $display("FAIL toggle_push_vector: got %0d expected 16", pv_n);
        else passed++;
        bad = 0;
        for (int i = 0; i < pm_q.size(); i++) begin
            exp_v = 8'h01 << (i % 8);
            if (pm_q[i] !== exp_v) bad++;
        end
        total++;
        if (pm_q.size() !== 16 || bad !== 0)
            $display("FAIL toggle_push_matrix: got %0d pushes %0d out of order expected 16 0", pm_q.size(), bad);
        else passed++;
        total++;
        if (pr_q.size() !== 2 || prs_q.size() !== 2)
            $display("FAIL toggle_results: got push %0d pop %0d expected 2 2", pr_q.size(), prs_q.size());
        else passed++;
        total++;
        if (done_q.size() !== 1 || busy !== 1'b0)
            $display("FAIL toggle_start_ignored: got done %0d busy %b expected 1 0", done_q.size(), busy);
        else passed++;
        total++;
        if (res_avail !== 1'b0) $display("FAIL toggle_res_avail: got %b expected 0", res_avail);
        else passed++;
    endtask

    task automatic test_occupancy();
        int k;
        int c;
        do_reset();
        start = 1'b1; n_rows = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (pm_q.size() < 24 && k < 200) begin @(posedge clk); #1; k++; end
        repeat (20) begin @(posedge clk); #1; end
        total++;
        if (pop_q.size() !== 16 || pr_q.size() !== 2)
            $display("FAIL occ_stall: got pops %0d results %0d expected 16 2", pop_q.size(), pr_q.size());
        else passed++;
        total++;
        if (in_ready !== 1'b0 || res_avail !== 1'b1 || busy !== 1'b1)
            $display("FAIL occ_stall_flags: in_ready=%b res_avail=%b busy=%b expected 0 1 1",
                     in_ready, res_avail, busy);
        else passed++;
        c = cyc;
        res_pop = 1'b1;
        @(posedge clk); #1;
        res_pop = 1'b0;
        total++;
        if (prs_q.size() !== 1 || prs_q[0] !== c)
            $display("FAIL occ_pop_result: got %0d pulses expected 1 in the res_pop cycle", prs_q.size());
        else passed++;
        k = 0;
        while (done_q.size() == 0 && k < 100) begin @(posedge clk); #1; k++; end
        in_valid = 1'b0;
        total++;
        if (done_q.size() !== 1) $display("FAIL occ_done: got %0d pulses expected 1", done_q.size());
        else passed++;
        total++;
        if (pr_q.size() !== 3 || pop_q.size() !== 24 || pm_q.size() !== 24)
            $display("FAIL occ_release: got results %0d pops %0d row beats %0d expected 3 24 24",
                     pr_q.size(), pop_q.size(), pm_q.size());
        else passed++;
        total++;
        if (pop_cyc_q.size() < 17 || pop_cyc_q[16] <= c)
            $display("FAIL occ_order: third row popped at %0d, res_pop at %0d, expected after",
                     (pop_cyc_q.size() > 16) ? pop_cyc_q[16] : -1, c);
        else passed++;
    endtask

    task automatic test_same_cycle();
        int k;
        int same_c;
        do_reset();
        res_pop = 1'b1;
        @(posedge clk); #1;
        res_pop = 1'b0;
        total++;
        if (prs_q.size() !== 0 || res_avail !== 1'b0)
            $display("FAIL empty_pop: got pop_result %0d res_avail %b expected 0 0", prs_q.size(), res_avail);
        else passed++;
        same_c = -1;
        start = 1'b1; n_rows = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_q.size() == 0 && k < 200) begin
            if (pr_q.size() == 1 && push_result) begin
                res_pop = 1'b1;
                same_c  = cyc;
            end else begin
                res_pop = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        res_pop = 1'b0; in_valid = 1'b0;
        total++;
        if (pr_q.size() !== 2 || prs_q.size() !== 1 || same_c < 0 || prs_q[0] !== same_c)
            $display("FAIL same_cycle_pop: got results %0d pops %0d expected 2 1 with pop on second push",
                     pr_q.size(), prs_q.size());
        else passed++;
        total++;
        if (res_avail !== 1'b1) $display("FAIL same_cycle_count: res_avail got %b expected 1", res_avail);
        else passed++;
        res_pop = 1'b1;
        @(posedge clk); #1;
        res_pop = 1'b0;
        total++;
        if (prs_q.size() !== 2 || res_avail !== 1'b0)
            $display("FAIL same_cycle_drain: got pops %0d res_avail %b expected 2 0", prs_q.size(), res_avail);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_zero_rows();
        test_back_to_back();
        test_occupancy();
        test_same_cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
